// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order commit buffer. Accepts dispatches from the
//                register file and forwards them to the reservation station
//                with operands resolved against the CDB and completed entries.
//                Captures CDB results and commits them in program order. A
//                committed jump flushes every entry and redirects fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int RobSize    = 16,
  parameter int AlmostFull = 14
) (
  input  logic        clk,
  input  logic        rst,
  // dispatch from register file
  input  logic        is_empty_from_rf,
  input  logic [5:0]  op_from_rf,
  input  logic [4:0]  rd_from_rf,
  input  logic [31:0] pc_from_rf,
  input  logic [31:0] imm_from_rf,
  input  logic [31:0] v1_from_rf,
  input  logic [31:0] v2_from_rf,
  input  logic [31:0] q1_from_rf,
  input  logic [31:0] q2_from_rf,
  output logic        is_full_to_decoder,
  // issue to reservation station
  output logic        is_empty_to_rs,
  output logic [5:0]  op_to_rs,
  output logic [31:0] pc_to_rs,
  output logic [31:0] imm_to_rs,
  output logic [31:0] v1_to_rs,
  output logic [31:0] v2_to_rs,
  output logic [31:0] q1_to_rs,
  output logic [31:0] q2_to_rs,
  // result broadcast
  input  logic        is_valid_from_cdb,
  input  logic [31:0] pc_from_cdb,
  input  logic [31:0] data_from_cdb,
  input  logic        is_jump_from_cdb,
  input  logic [31:0] target_from_cdb,
  // commit / redirect
  output logic        is_finish_to_rf,
  output logic [4:0]  rd_to_rf,
  output logic [31:0] data_to_rf,
  output logic [31:0] pc_to_rf,
  output logic        is_exception_to_rf,
  output logic [31:0] pc_to_fetch
);

  localparam int c_IDX_W = $clog2(RobSize);
  localparam int c_CNT_W = c_IDX_W + 1;

  // entry status (reset) and payload (no reset, qualified by busy)
  logic [RobSize-1:0] busy_q, busy_d, ready_q, ready_d, jump_q;
  logic [31:0]        pc_q     [RobSize];
  logic [31:0]        data_q   [RobSize];
  logic [31:0]        target_q [RobSize];
  logic [4:0]         rd_q     [RobSize];

  logic [c_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               is_full_q;

  // last committed values, held while the strobes are low
  logic [4:0]  last_rd_q;
  logic [31:0] last_data_q, last_pc_q, last_fetch_q;

  logic               w_commit, w_flush, w_dispatch, w_cdb_en;
  logic [RobSize-1:0] w_cdb_hit;
  logic [4:0]         w_commit_rd;
  logic [31:0]        w_commit_data;
  logic [31:0]        w_v1_res, w_v2_res, w_q1_res, w_q2_res;

  // Commit/flush/dispatch decisions. A commit at a full buffer frees the slot
  // the same-cycle dispatch reuses, so occupancy stays constant.
  always_comb begin
    w_commit      = !rst && busy_q[head_q] && ready_q[head_q];
    w_flush       = w_commit && jump_q[head_q];
    w_dispatch    = !rst && !w_flush && !is_empty_from_rf &&
                    ((count_q < c_CNT_W'(RobSize)) || w_commit);
    w_cdb_en      = !rst && !w_flush && is_valid_from_cdb;
    w_commit_rd   = rd_q[head_q];
    w_commit_data = (rd_q[head_q] == 5'd0) ? 32'd0 : data_q[head_q];
    for (int i = 0; i < RobSize; i++) begin
      w_cdb_hit[i] = w_cdb_en && busy_q[i] && (pc_q[i] == pc_from_cdb);
    end
  end

  // Next-state for pointers, occupancy and entry status bits.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q | w_cdb_hit;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + c_IDX_W'(1);
    end
    if (w_dispatch) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + c_IDX_W'(1);
    end
    if (w_dispatch && !w_commit) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (w_commit && !w_dispatch) begin
      count_d = count_q - c_CNT_W'(1);
    end
    if (w_flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Operand resolution: a completed entry supplies the value, the same-cycle
  // CDB broadcast overrides it.
  always_comb begin
    w_v1_res = v1_from_rf;
    w_q1_res = q1_from_rf;
    w_v2_res = v2_from_rf;
    w_q2_res = q2_from_rf;
    for (int i = 0; i < RobSize; i++) begin
      if (busy_q[i] && ready_q[i]) begin
        if (q1_from_rf != 32'd0 && pc_q[i] == q1_from_rf) begin
          w_v1_res = data_q[i];
          w_q1_res = 32'd0;
        end
        if (q2_from_rf != 32'd0 && pc_q[i] == q2_from_rf) begin
          w_v2_res = data_q[i];
          w_q2_res = 32'd0;
        end
      end
    end
    if (is_valid_from_cdb) begin
      if (q1_from_rf != 32'd0 && pc_from_cdb == q1_from_rf) begin
        w_v1_res = data_from_cdb;
        w_q1_res = 32'd0;
      end
      if (q2_from_rf != 32'd0 && pc_from_cdb == q2_from_rf) begin
        w_v2_res = data_from_cdb;
        w_q2_res = 32'd0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      ready_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      is_full_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      is_full_q <= (count_d >= c_CNT_W'(AlmostFull));
    end
  end

  // Entry payload: CDB result capture, then new dispatch into the tail slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RobSize; i++) begin
      if (w_cdb_hit[i]) begin
        data_q[i]   <= data_from_cdb;
        jump_q[i]   <= is_jump_from_cdb;
        target_q[i] <= target_from_cdb;
      end
      if (w_dispatch && tail_q == c_IDX_W'(i)) begin
        pc_q[i]     <= pc_from_rf;
        rd_q[i]     <= rd_from_rf;
        data_q[i]   <= 32'd0;
        jump_q[i]   <= 1'b0;
        target_q[i] <= 32'd0;
      end
    end
  end

  // Issue register: each accepted dispatch appears at the RS one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_empty_to_rs <= 1'b1;
      op_to_rs       <= '0;
      pc_to_rs       <= '0;
      imm_to_rs      <= '0;
      v1_to_rs       <= '0;
      v2_to_rs       <= '0;
      q1_to_rs       <= '0;
      q2_to_rs       <= '0;
    end else begin
      is_empty_to_rs <= !w_dispatch;
      if (w_dispatch) begin
        op_to_rs  <= op_from_rf;
        pc_to_rs  <= pc_from_rf;
        imm_to_rs <= imm_from_rf;
        v1_to_rs  <= w_v1_res;
        v2_to_rs  <= w_v2_res;
        q1_to_rs  <= w_q1_res;
        q2_to_rs  <= w_q2_res;
      end
    end
  end

  // Remember the last committed values so the outputs hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q    <= '0;
      last_data_q  <= '0;
      last_pc_q    <= '0;
      last_fetch_q <= '0;
    end else begin
      if (w_commit) begin
        last_rd_q   <= w_commit_rd;
        last_data_q <= w_commit_data;
        last_pc_q   <= pc_q[head_q];
      end
      if (w_flush) begin
        last_fetch_q <= target_q[head_q];
      end
    end
  end

  assign is_full_to_decoder = is_full_q;
  assign is_finish_to_rf    = w_commit;
  assign rd_to_rf           = w_commit ? w_commit_rd   : last_rd_q;
  assign data_to_rf         = w_commit ? w_commit_data : last_data_q;
  assign pc_to_rf           = w_commit ? pc_q[head_q]  : last_pc_q;
  assign is_exception_to_rf = w_flush;
  assign pc_to_fetch        = w_flush ? target_q[head_q] : last_fetch_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Directed self-checking bench for reorder_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_empty_from_rf;
  logic [5:0]  op_from_rf;
  logic [4:0]  rd_from_rf;
  logic [31:0] pc_from_rf, imm_from_rf, v1_from_rf, v2_from_rf, q1_from_rf, q2_from_rf;
  logic        is_full_to_decoder;
  logic        is_empty_to_rs;
  logic [5:0]  op_to_rs;
  logic [31:0] pc_to_rs, imm_to_rs, v1_to_rs, v2_to_rs, q1_to_rs, q2_to_rs;
  logic        is_valid_from_cdb, is_jump_from_cdb;
  logic [31:0] pc_from_cdb, data_from_cdb, target_from_cdb;
  logic        is_finish_to_rf;
  logic [4:0]  rd_to_rf;
  logic [31:0] data_to_rf, pc_to_rf;
  logic        is_exception_to_rf;
  logic [31:0] pc_to_fetch;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer #(.RobSize(16), .AlmostFull(14)) dut (
    .clk(clk), .rst(rst),
    .is_empty_from_rf(is_empty_from_rf), .op_from_rf(op_from_rf), .rd_from_rf(rd_from_rf),
    .pc_from_rf(pc_from_rf), .imm_from_rf(imm_from_rf),
    .v1_from_rf(v1_from_rf), .v2_from_rf(v2_from_rf),
    .q1_from_rf(q1_from_rf), .q2_from_rf(q2_from_rf),
    .is_full_to_decoder(is_full_to_decoder),
    .is_empty_to_rs(is_empty_to_rs), .op_to_rs(op_to_rs), .pc_to_rs(pc_to_rs),
    .imm_to_rs(imm_to_rs), .v1_to_rs(v1_to_rs), .v2_to_rs(v2_to_rs),
    .q1_to_rs(q1_to_rs), .q2_to_rs(q2_to_rs),
    .is_valid_from_cdb(is_valid_from_cdb), .pc_from_cdb(pc_from_cdb),
    .data_from_cdb(data_from_cdb), .is_jump_from_cdb(is_jump_from_cdb),
    .target_from_cdb(target_from_cdb),
    .is_finish_to_rf(is_finish_to_rf), .rd_to_rf(rd_to_rf), .data_to_rf(data_to_rf),
    .pc_to_rf(pc_to_rf), .is_exception_to_rf(is_exception_to_rf), .pc_to_fetch(pc_to_fetch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_empty_from_rf  = 1'b1;
    op_from_rf        = '0;
    rd_from_rf        = '0;
    pc_from_rf        = '0;
    imm_from_rf       = '0;
    v1_from_rf        = '0;
    v2_from_rf        = '0;
    q1_from_rf        = '0;
    q2_from_rf        = '0;
    is_valid_from_cdb = 1'b0;
    pc_from_cdb       = '0;
    data_from_cdb     = '0;
    is_jump_from_cdb  = 1'b0;
    target_from_cdb   = '0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] q1, input logic [31:0] v1,
                      input logic [31:0] q2, input logic [31:0] v2);
    is_empty_from_rf = 1'b0;
    op_from_rf       = 6'h2A;
    rd_from_rf       = rd;
    pc_from_rf       = pc;
    imm_from_rf      = pc + 32'h1;
    q1_from_rf       = q1;
    v1_from_rf       = v1;
    q2_from_rf       = q2;
    v2_from_rf       = v2;
  endtask

  task automatic cdb(input logic [31:0] pc, input logic [31:0] data,
                     input logic jump, input logic [31:0] target);
    is_valid_from_cdb = 1'b1;
    pc_from_cdb       = pc;
    data_from_cdb     = data;
    is_jump_from_cdb  = jump;
    target_from_cdb   = target;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_empty_rs", 32'(is_empty_to_rs), 32'd1);
    check("rst_full", 32'(is_full_to_decoder), 32'd0);
    check("rst_finish", 32'(is_finish_to_rf), 32'd0);
    check("rst_exc", 32'(is_exception_to_rf), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);
    rst = 1'b0;

    // single dispatch, complete, commit
    disp(32'h10, 5'd3, 0, 0, 0, 0); tick();
    check("d1_issue", 32'(is_empty_to_rs), 32'd0);
    check("d1_pc_rs", pc_to_rs, 32'h10);
    check("d1_imm_rs", imm_to_rs, 32'h11);
    check("d1_count", 32'(dut.count_q), 32'd1);
    idle(); cdb(32'h10, 32'hAB, 1'b0, 0); tick();
    check("c1_finish", 32'(is_finish_to_rf), 32'd1);
    check("c1_rd", 32'(rd_to_rf), 32'd3);
    check("c1_data", data_to_rf, 32'hAB);
    check("c1_pc", pc_to_rf, 32'h10);
    check("c1_issue_idle", 32'(is_empty_to_rs), 32'd1);
    idle(); tick();
    check("c1_finish_off", 32'(is_finish_to_rf), 32'd0);
    check("c1_count", 32'(dut.count_q), 32'd0);
    check("c1_rd_hold", 32'(rd_to_rf), 32'd3);

    // same-cycle CDB bypass on q1, q2 unmatched passes through
    disp(32'h30, 5'd4, 32'h20, 32'h99, 32'h77, 32'h11); cdb(32'h20, 32'd5, 1'b0, 0); tick();
    check("byp_v1", v1_to_rs, 32'd5);
    check("byp_q1", q1_to_rs, 32'd0);
    check("byp_v2", v2_to_rs, 32'h11);
    check("byp_q2", q2_to_rs, 32'h77);
    idle(); cdb(32'h30, 32'h33, 1'b0, 0); tick();
    check("byp_commit", data_to_rf, 32'h33);
    idle(); tick();
    check("byp_count", 32'(dut.count_q), 32'd0);

    // out-of-order completion, in-order commit, forwarding from ready entries
    disp(32'h100, 5'd1, 0, 0, 0, 0); tick();
    disp(32'h104, 5'd2, 0, 0, 0, 0); tick();
    disp(32'h108, 5'd3, 0, 0, 0, 0); tick();
    idle(); cdb(32'h108, 32'd8, 1'b0, 0); tick();
    check("ooo_wait2", 32'(is_finish_to_rf), 32'd0);
    idle(); cdb(32'h104, 32'd4, 1'b0, 0); tick();
    check("ooo_wait1", 32'(is_finish_to_rf), 32'd0);
    idle(); disp(32'h10C, 5'd0, 32'h104, 0, 32'h108, 0); tick();
    check("fwd_v1", v1_to_rs, 32'd4);
    check("fwd_q1", q1_to_rs, 32'd0);
    check("fwd_v2", v2_to_rs, 32'd8);
    check("fwd_q2", q2_to_rs, 32'd0);
    idle(); cdb(32'h100, 32'd1, 1'b0, 0); tick();
    check("ooo_c0_fin", 32'(is_finish_to_rf), 32'd1);
    check("ooo_c0_pc", pc_to_rf, 32'h100);
    check("ooo_c0_rd", 32'(rd_to_rf), 32'd1);
    idle(); tick();
    check("ooo_c1_pc", pc_to_rf, 32'h104);
    check("ooo_c1_data", data_to_rf, 32'd4);
    tick();
    check("ooo_c2_pc", pc_to_rf, 32'h108);
    check("ooo_c2_rd", 32'(rd_to_rf), 32'd3);
    tick();
    check("ooo_stall", 32'(is_finish_to_rf), 32'd0);
    check("ooo_hold_pc", pc_to_rf, 32'h108);
    cdb(32'h10C, 32'hFF, 1'b0, 0); tick();
    check("rd0_fin", 32'(is_finish_to_rf), 32'd1);
    check("rd0_rd", 32'(rd_to_rf), 32'd0);
    check("rd0_data", data_to_rf, 32'd0);
    idle(); tick();
    check("ooo_count", 32'(dut.count_q), 32'd0);

    // jump at head flushes younger entries
    for (int i = 0; i < 4; i++) begin
      disp(32'h200 + 32'(4 * i), 5'd5, 0, 0, 0, 0); tick();
    end
    idle(); cdb(32'h200, 32'd1, 1'b1, 32'h400); tick();
    check("jmp_exc", 32'(is_exception_to_rf), 32'd1);
    check("jmp_fetch", pc_to_fetch, 32'h400);
    check("jmp_finish", 32'(is_finish_to_rf), 32'd1);
    idle(); disp(32'h500, 5'd6, 0, 0, 0, 0); cdb(32'h204, 32'd7, 1'b0, 0); tick();
    check("jmp_count", 32'(dut.count_q), 32'd0);
    check("jmp_exc_off", 32'(is_exception_to_rf), 32'd0);
    check("jmp_no_commit", 32'(is_finish_to_rf), 32'd0);
    check("jmp_no_issue", 32'(is_empty_to_rs), 32'd1);
    check("jmp_fetch_hold", pc_to_fetch, 32'h400);
    idle(); cdb(32'h208, 32'd9, 1'b0, 0); tick();
    check("jmp_quiet", 32'(is_finish_to_rf), 32'd0);

    // fill to capacity, almost-full threshold, drop, wrap
    idle();
    for (int i = 0; i < 17; i++) begin
      disp(32'h1000 + 32'(4 * i), 5'(i + 1), 0, 0, 0, 0); tick();
      if (i == 12) begin
        check("fill13_full", 32'(is_full_to_decoder), 32'd0);
        check("fill13_count", 32'(dut.count_q), 32'd13);
      end
      if (i == 13) begin
        check("fill14_full", 32'(is_full_to_decoder), 32'd1);
        check("fill14_count", 32'(dut.count_q), 32'd14);
      end
      if (i == 15) begin
        check("fill16_count", 32'(dut.count_q), 32'd16);
        check("fill16_tail", 32'(dut.tail_q), 32'd0);
      end
      if (i == 16) begin
        check("drop_issue", 32'(is_empty_to_rs), 32'd1);
        check("drop_count", 32'(dut.count_q), 32'd16);
      end
    end

    // commit and dispatch together at full
    idle(); cdb(32'h1000, 32'h42, 1'b0, 0); tick();
    check("full_commit", 32'(is_finish_to_rf), 32'd1);
    idle(); disp(32'h2000, 5'd9, 0, 0, 0, 0); tick();
    check("full_swap_count", 32'(dut.count_q), 32'd16);
    check("full_swap_issue", 32'(is_empty_to_rs), 32'd0);
    check("full_swap_pc", pc_to_rs, 32'h2000);

    // reset with several ready entries behind a non-ready head
    idle();
    for (int i = 0; i < 5; i++) begin
      cdb(32'h1008 + 32'(4 * i), 32'(i), 1'b0, 0); tick();
    end
    check("pre_rst_stall", 32'(is_finish_to_rf), 32'd0);
    idle(); disp(32'h3000, 5'd7, 0, 0, 0, 0); cdb(32'h1004, 32'd1, 1'b0, 0);
    rst = 1'b1; tick();
    check("rst2_count", 32'(dut.count_q), 32'd0);
    check("rst2_issue", 32'(is_empty_to_rs), 32'd1);
    check("rst2_finish", 32'(is_finish_to_rf), 32'd0);
    check("rst2_rd", 32'(rd_to_rf), 32'd0);
    check("rst2_data", data_to_rf, 32'd0);
    check("rst2_pc", pc_to_rf, 32'd0);
    check("rst2_fetch", pc_to_fetch, 32'd0);
    check("rst2_full", 32'(is_full_to_decoder), 32'd0);
    rst = 1'b0; idle(); disp(32'h3000, 5'd7, 0, 0, 0, 0); tick();
    check("post_rst_count", 32'(dut.count_q), 32'd1);
    check("post_rst_issue", 32'(is_empty_to_rs), 32'd0);
    check("post_rst_pc", pc_to_rs, 32'h3000);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter RobSize, default 16, number of entries (power of two).
REQ-002 SHALL have parameter AlmostFull, default 14, count at or above which decoder is stalled.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port is_empty_from_rf  input  1  1 = no dispatch this cycle.
REQ-006 SHALL have ports op_from_rf/rd_from_rf  input  6/5  opcode, destination register.
REQ-007 SHALL have ports pc_from_rf/imm_from_rf  input  32/32  instruction pc (also its tag), immediate.
REQ-008 SHALL have ports v1_from_rf/v2_from_rf/q1_from_rf/q2_from_rf  input  32 each  operand values and producer tags (0 = value valid).
REQ-009 SHALL have port is_full_to_decoder  output  1  stall request.
REQ-010 SHALL have ports is_empty_to_rs, op_to_rs, pc_to_rs, imm_to_rs, v1_to_rs, v2_to_rs, q1_to_rs, q2_to_rs  output  1/6/32/32/32/32/32/32  issue to reservation station.
REQ-011 SHALL have ports is_valid_from_cdb, pc_from_cdb, data_from_cdb, is_jump_from_cdb, target_from_cdb  input  1/32/32/1/32  result broadcast.
REQ-012 SHALL have ports is_finish_to_rf, rd_to_rf, data_to_rf, pc_to_rf  output  1/5/32/32  commit.
REQ-013 SHALL have ports is_exception_to_rf, pc_to_fetch  output  1/32  flush and redirect.

Function
REQ-014 SHALL keep a circular buffer with head, tail (log2 RobSize bits, wrap modulo RobSize) and count 0..RobSize; entry = {busy, ready, pc, rd, op, data, jump, target}.
REQ-015 SHALL drive is_full_to_decoder = (count >= AlmostFull), registered, covering the one-cycle regfile latency.
REQ-016 SHALL, when is_empty_from_rf=0 and count<RobSize, write entry at tail {busy=1, ready=0, data=0, jump=0} and advance tail; at count=RobSize the dispatch SHALL be dropped with state unchanged.
REQ-017 SHALL issue each dispatch to the RS one cycle later (is_empty_to_rs=0 for exactly one cycle), else is_empty_to_rs=1.
REQ-018 SHALL resolve each nonzero qN before issue: same-cycle CDB with pc_from_cdb=qN gives vN=data_from_cdb, qN=0; else a busy ready entry with pc=qN gives vN=entry data, qN=0; else pass through unchanged; CDB takes priority.
REQ-019 SHALL, on is_valid_from_cdb=1, set ready, data, jump, target in the busy entry whose pc matches; no match SHALL be ignored.
REQ-020 SHALL commit at most one entry per cycle: when head entry is busy and ready, pulse is_finish_to_rf=1 for one cycle with its rd, data, pc; clear busy; advance head.
REQ-021 SHALL drive rd_to_rf=0 and data_to_rf=0 on commit of an entry with rd=0.
REQ-022 SHALL treat ready as registered: a CDB write to the head entry commits no earlier than the next cycle.
REQ-023 SHALL, on commit of an entry with jump=1, additionally pulse is_exception_to_rf=1 with pc_to_fetch=target, clear all busy bits, set head=tail=count=0, ignore any same-cycle dispatch and CDB, and hold is_empty_to_rs=1 next cycle.
REQ-024 SHALL leave count unchanged on simultaneous dispatch and non-flushing commit, including at count=RobSize.
REQ-025 SHALL hold pc_to_fetch, rd_to_rf, data_to_rf, pc_to_rf at last values when the respective strobe is 0.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, clear head, tail, count, all busy/ready bits and drive all outputs 0 except is_empty_to_rs=1, overriding any commit, dispatch, CDB or flush in that cycle.
REQ-027 SHALL resume dispatch acceptance in the first cycle after rst deasserts.

Verification
REQ-028 SHALL pass: dispatch pc=0x10 rd=3, CDB pc=0x10 data=0xAB -> next cycle is_finish_to_rf=1, rd=3, data=0xAB, pc=0x10; count back to 0.
REQ-029 SHALL pass: 14 dispatches without CDB -> is_full_to_decoder=1 after the 14th; 17th dispatch dropped, count=16; tail wraps to 0.
REQ-030 SHALL pass: dispatch q1=0x20 in the same cycle as CDB pc=0x20 data=5 -> issue v1=5, q1=0.
REQ-031 SHALL pass: head entry CDB jump=1 target=0x400 with 3 younger entries -> is_exception_to_rf=1, pc_to_fetch=0x400, count=0, no further commits.
REQ-032 SHALL pass: out-of-order CDB for entries 2 then 1 then 0 -> commits in order 0,1,2 on consecutive cycles.
REQ-033 SHALL pass: rst asserted with 5 ready entries -> no is_finish_to_rf, count=0, is_empty_to_rs=1.
